cp0_exc_unit: RTL

Parametrised CP0 system-control block for the pipelined MIPS core: holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config, records exceptions from the MEM stage, and raises the interrupt request back to the pipeline. It sits beside the MEM/WB boundary. It generalises the earlier CP0 in four ways: configurable hardware-interrupt count, timer prescaler, BadVAddr capture, and masked interrupt-request generation with explicit nested-exception and ERET semantics.

---
 rtl/cp0_pkg.sv | 40 ++++
 rtl/cp0_timer.sv | 46 ++++
 rtl/cp0_exc_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and reset values. Also imported by the core decode stage.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;

  localparam int STATUS_IE      = 0;
  localparam int STATUS_EXL     = 1;
  localparam int CAUSE_BD       = 31;
  localparam int CAUSE_TI       = 30;
  localparam int CAUSE_IP_HW_LO = 10;
  localparam int CAUSE_IP_SW_LO = 8;
  localparam int CAUSE_EXC_LO   = 2;

  localparam logic [31:0] STATUS_RST = 32'h1000_0000;

  // Only address-error exceptions carry a meaningful faulting address.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: prescaler, Count, Compare and the latched timer interrupt.
module cp0_timer #(
  parameter int TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  localparam logic [7:0] DIV_MAX = 8'(TIMER_DIV - 1);

  logic [7:0] presc;
  logic       wrap;

  assign wrap = (presc == DIV_MAX);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      presc <= wrap ? 8'd0 : presc + 8'd1;

      if (count_we)  count <= wdata;
      else if (wrap) count <= count + 32'd1;

      if (compare_we) compare <= wdata;

      // A Compare write acknowledges the interrupt even if it also matches.
      if (compare_we)
        timer_int <= 1'b0;
      else if ((compare != 32'd0) && (count == compare))
        timer_int <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 system-control block: Status/Cause/EPC/BadVAddr, exception and ERET
// handling, MFC0 read mux and interrupt-request generation.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter int          TIMER_DIV  = 1,
  parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           rdata_o,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic                  eret_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delay_slot_i,
  input  logic [31:0]           badvaddr_i,
  input  logic [NUM_HW_INT-1:0] hw_int_i,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           badvaddr_o,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic                  timer_int_o,
  output logic                  int_req_o
);

  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic        bd;
  logic [4:0]  exc_code;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw;
  logic [5:0]  hw_ext;
  logic [31:0] cause;
  logic        first_exc;

  cp0_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (we_i && (waddr_i == REG_COUNT)),
    .compare_we (we_i && (waddr_i == REG_COMPARE)),
    .wdata      (wdata_i),
    .count      (count_o),
    .compare    (compare_o),
    .timer_int  (timer_int_o)
  );

  // NOTE: combinational blocks assign a default to every output first so no
  // path leaves a variable unassigned and infers a latch.
  always_comb begin
    hw_ext                 = '0;
    hw_ext[NUM_HW_INT-1:0] = hw_int_i;
  end

  // A nested exception (EXL already set) must not overwrite EPC or BD.
  assign first_exc = exc_valid_i && !status[STATUS_EXL];

  always_ff @(posedge clk) begin
    if (rst) begin
      status   <= STATUS_RST;
      epc      <= '0;
      badvaddr <= '0;
      bd       <= 1'b0;
      exc_code <= '0;
      ip_sw    <= '0;
      ip_hw    <= '0;
    end else begin
      ip_hw <= hw_ext;

      // Later assignments to EXL override the MTC0 value: exception > ERET > MTC0.
      if (we_i && (waddr_i == REG_STATUS)) status <= wdata_i;
      if (exc_valid_i)  status[STATUS_EXL] <= 1'b1;
      else if (eret_i)  status[STATUS_EXL] <= 1'b0;

      if (first_exc)
        epc <= in_delay_slot_i ? pc_i - 32'd4 : pc_i;
      else if (we_i && (waddr_i == REG_EPC))
        epc <= wdata_i;

      if (first_exc)   bd       <= in_delay_slot_i;
      if (exc_valid_i) exc_code <= exc_code_i;

      if (we_i && (waddr_i == REG_CAUSE)) ip_sw <= wdata_i[9:8];

      if (exc_valid_i && is_addr_exc(exc_code_i))
        badvaddr <= badvaddr_i;
      else if (we_i && (waddr_i == REG_BADVADDR))
        badvaddr <= wdata_i;
    end
  end

  always_comb begin
    cause                             = '0;
    cause[CAUSE_BD]                   = bd;
    cause[CAUSE_TI]                   = timer_int_o;
    cause[CAUSE_IP_HW_LO +: 6]        = ip_hw | {timer_int_o, 5'b0};
    cause[CAUSE_IP_SW_LO +: 2]        = ip_sw;
    cause[CAUSE_EXC_LO +: 5]          = exc_code;
  end

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr;
      REG_COUNT:    rdata_o = count_o;
      REG_COMPARE:  rdata_o = compare_o;
      REG_STATUS:   rdata_o = status;
      REG_CAUSE:    rdata_o = cause;
      REG_EPC:      rdata_o = epc;
      REG_PRID:     rdata_o = PRID_VAL;
      REG_CONFIG:   rdata_o = CONFIG_VAL;
      default:      rdata_o = '0;
    endcase
  end

  assign status_o   = status;
  assign cause_o    = cause;
  assign epc_o      = epc;
  assign badvaddr_o = badvaddr;
  assign int_req_o  = status[STATUS_IE] && !status[STATUS_EXL] &&
                      (|(cause[15:8] & status[15:8]));

endmodule
